// File: rtl/pll_lock_seq_pkg.sv
// Shared types for the PLL configuration and lock sequencer.
// The state encoding is visible to software through state_o.
package pll_seq_pkg;

    localparam int REFDIV_W_DEF = 8;
    localparam int FBDIV_W_DEF  = 12;
    localparam int PD1_W_DEF    = 4;
    localparam int PD2_W_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STABLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAULT  = 3'd5,
        ST_BYPASS = 3'd6
    } pll_state_e;

    typedef struct packed {
        logic [REFDIV_W_DEF-1:0] refdiv;
        logic [FBDIV_W_DEF-1:0]  fbdiv;
        logic [PD1_W_DEF-1:0]    postdiv1;
        logic [PD2_W_DEF-1:0]    postdiv2;
        logic                    bp;
    } pll_cfg_t;

    // States in which a new configuration may be accepted
    function automatic logic state_accepts(input pll_state_e st);
        case (st)
            ST_IDLE, ST_LOCKED, ST_FAULT, ST_BYPASS: state_accepts = 1'b1;
            default:                                 state_accepts = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// Configuration request channel from the sysctrl CSRs to the PLL sequencer.
interface pll_lock_seq_if #(
    parameter int REFDIV_W = 8,
    parameter int FBDIV_W  = 12,
    parameter int PD1_W    = 4,
    parameter int PD2_W    = 2
);
    logic                cfg_valid_i;
    logic                cfg_ready_o;
    logic [REFDIV_W-1:0] cfg_refdiv_i;
    logic [FBDIV_W-1:0]  cfg_fbdiv_i;
    logic [PD1_W-1:0]    cfg_postdiv1_i;
    logic [PD2_W-1:0]    cfg_postdiv2_i;
    logic                cfg_bp_i;

    modport master (
        output cfg_valid_i, cfg_refdiv_i, cfg_fbdiv_i, cfg_postdiv1_i, cfg_postdiv2_i, cfg_bp_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_refdiv_i, cfg_fbdiv_i, cfg_postdiv1_i, cfg_postdiv2_i, cfg_bp_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/pll_lock_seq_chk.sv
// Elaboration-time parameter checks for the PLL lock sequencer.
module pll_lock_seq_chk #(
    parameter int CNT_W       = 20,
    parameter int RST_CYC     = 16,
    parameter int LOCK_CYC    = 'h1FFFF,
    parameter int STABLE_CYC  = 64,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2
);
    localparam longint MAX_A    = (RST_CYC > LOCK_CYC) ? longint'(RST_CYC) : longint'(LOCK_CYC);
    localparam longint MAX_CYC  = (MAX_A > longint'(STABLE_CYC)) ? MAX_A : longint'(STABLE_CYC);
    localparam longint CNT_SPAN = 64'sd1 <<< CNT_W;

    if (MAX_CYC > CNT_SPAN) begin : g_bad_cnt_w
        $error("pll_lock_seq: CNT_W too narrow for the longest timer interval");
    end
    if (RST_CYC < 1 || LOCK_CYC < 1 || STABLE_CYC < 1) begin : g_bad_cyc
        $error("pll_lock_seq: cycle counts must be at least 1");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
        $error("pll_lock_seq: MAX_RETRY must fit the 2-bit retry counter");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pll_lock_seq: SYNC_STAGES must be at least 2");
    end
endmodule

// File: rtl/pll_lock_seq_sync.sv
// Reset-to-zero multi-flop synchroniser for the asynchronous PLL lock detect.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_r[STAGES-1];
endmodule

// File: rtl/pll_lock_seq.sv
// PLL configuration and lock sequencer: programs dividers under reset, waits for lock,
// retries on timeout, parks in FAULT after the last retry and flags runtime lock loss.
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int REFDIV_W    = 8,
    parameter int FBDIV_W     = 12,
    parameter int PD1_W       = 4,
    parameter int PD2_W       = 2,
    parameter int CNT_W       = 20,
    parameter int RST_CYC     = 16,
    parameter int LOCK_CYC    = 'h1FFFF,
    parameter int STABLE_CYC  = 64,
    parameter int MAX_RETRY   = 3,
    parameter int HAS_LKDT    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pll_lock_seq_if.slave       cfg,
    output logic [REFDIV_W-1:0] pll_refdiv_o,
    output logic [FBDIV_W-1:0]  pll_fbdiv_o,
    output logic [PD1_W-1:0]    pll_postdiv1_o,
    output logic [PD2_W-1:0]    pll_postdiv2_o,
    output logic                pll_rst_o,
    output logic                pll_bp_o,
    input  logic                pll_lkdt_i,
    output logic                lock_o,
    output logic                fault_o,
    output logic                lock_lost_o,
    output logic [1:0]          retry_cnt_o,
    output logic [2:0]          state_o
);
    localparam logic [CNT_W-1:0] TIMER_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);
    localparam logic             USE_LKDT    = (HAS_LKDT != 0);

    pll_state_e       state_r, state_s, retry_state_s;
    logic [CNT_W-1:0] timer_r, timer_s;
    logic [1:0]       retry_r, retry_s, retry_inc_s;
    logic             lock_lost_r, lost_s;
    logic             lkdt_s, accept_s;
    logic             rst_s, bp_s, lock_s, fault_s, ready_s;

    pll_lock_seq_chk #(
        .CNT_W(CNT_W), .RST_CYC(RST_CYC), .LOCK_CYC(LOCK_CYC),
        .STABLE_CYC(STABLE_CYC), .MAX_RETRY(MAX_RETRY), .SYNC_STAGES(SYNC_STAGES)
    ) u_chk ();

    sync_nff #(.STAGES(SYNC_STAGES)) u_lkdt_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lkdt_i),
        .q_o   (lkdt_s)
    );

    assign accept_s      = cfg.cfg_valid_i && cfg.cfg_ready_o;
    // A failed attempt either starts another one or gives up
    assign retry_state_s = (retry_r < RETRY_MAX) ? ST_RESET : ST_FAULT;
    assign retry_inc_s   = (retry_r < RETRY_MAX) ? (retry_r + 2'd1) : retry_r;

    // State, timer, retry count and sticky lock-loss registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            timer_r     <= TIMER_ZERO;
            retry_r     <= 2'd0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            retry_r     <= retry_s;
            lock_lost_r <= lost_s;
        end
    end

    // Next-state and timer decisions; an accept overrides every in-flight sequence
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        retry_s = retry_r;
        lost_s  = lock_lost_r;
        if (accept_s) begin
            state_s = cfg.cfg_bp_i ? ST_BYPASS : ST_RESET;
            timer_s = TIMER_ZERO;
            retry_s = 2'd0;
            lost_s  = 1'b0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (timer_r == RST_LAST) begin
                        state_s = ST_WAIT;
                        timer_s = TIMER_ZERO;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                ST_WAIT: begin
                    if (USE_LKDT && lkdt_s) begin
                        state_s = ST_STABLE;
                        timer_s = TIMER_ZERO;
                    end else if (timer_r == LOCK_LAST) begin
                        timer_s = TIMER_ZERO;
                        if (USE_LKDT) begin
                            state_s = retry_state_s;
                            retry_s = retry_inc_s;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lkdt_s) begin
                        state_s = retry_state_s;
                        retry_s = retry_inc_s;
                        timer_s = TIMER_ZERO;
                    end else if (timer_r == STABLE_LAST) begin
                        state_s = ST_LOCKED;
                        timer_s = TIMER_ZERO;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (USE_LKDT && !lkdt_s) begin
                        state_s = ST_RESET;
                        timer_s = TIMER_ZERO;
                        retry_s = 2'd0;
                        lost_s  = 1'b1;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                ST_IDLE, ST_FAULT, ST_BYPASS: begin
                    state_s = state_r;
                end
                default: begin
                    state_s = ST_IDLE;
                    timer_s = TIMER_ZERO;
                    retry_s = 2'd0;
                end
            endcase
        end
    end

    // Pin levels decoded from the state being entered, so they change on the entry edge
    always_comb begin
        rst_s   = 1'b1;
        bp_s    = 1'b1;
        lock_s  = 1'b0;
        fault_s = 1'b0;
        ready_s = state_accepts(state_s);
        case (state_s)
            ST_WAIT, ST_STABLE: begin
                rst_s = 1'b0;
            end
            ST_LOCKED: begin
                rst_s  = 1'b0;
                bp_s   = 1'b0;
                lock_s = 1'b1;
            end
            ST_FAULT: begin
                fault_s = 1'b1;
            end
            default: begin
                rst_s = 1'b1;
                bp_s  = 1'b1;
            end
        endcase
    end

    // Registered PLL pins; dividers load only on accept, while the PLL is held in reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pll_rst_o       <= 1'b1;
            pll_bp_o        <= 1'b1;
            lock_o          <= 1'b0;
            fault_o         <= 1'b0;
            cfg.cfg_ready_o <= 1'b1;
            pll_refdiv_o    <= {REFDIV_W{1'b0}};
            pll_fbdiv_o     <= {FBDIV_W{1'b0}};
            pll_postdiv1_o  <= {PD1_W{1'b0}};
            pll_postdiv2_o  <= {PD2_W{1'b0}};
        end else begin
            pll_rst_o       <= rst_s;
            pll_bp_o        <= bp_s;
            lock_o          <= lock_s;
            fault_o         <= fault_s;
            cfg.cfg_ready_o <= ready_s;
            if (accept_s) begin
                pll_refdiv_o   <= cfg.cfg_refdiv_i;
                pll_fbdiv_o    <= cfg.cfg_fbdiv_i;
                pll_postdiv1_o <= cfg.cfg_postdiv1_i;
                pll_postdiv2_o <= cfg.cfg_postdiv2_i;
            end else begin
                pll_refdiv_o   <= pll_refdiv_o;
                pll_fbdiv_o    <= pll_fbdiv_o;
                pll_postdiv1_o <= pll_postdiv1_o;
                pll_postdiv2_o <= pll_postdiv2_o;
            end
        end
    end

    assign state_o     = state_r;
    assign retry_cnt_o = retry_r;
    assign lock_lost_o = lock_lost_r;
endmodule
